// File: rtl/negate_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | negate_scheduler: round-robin shared bit-serial two's-complement negator |
// | Optional macro NEGSCHED_SAT_EN: saturate -(2^(WIDTH-1)) to 2^(WIDTH-1)-1 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module negate_scheduler #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   din_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [$clog2(NREQ)-1:0] done_id_o,
    output logic [WIDTH-1:0]        dout_o,
    output logic                    ovf_o
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] c_MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             seen_q, seen_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   rr_last_q, rr_last_d;
    logic             min_op_q, min_op_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic             done_q, done_d;
    logic [IDW-1:0]   done_id_q, done_id_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;

    logic             win_valid;
    logic [IDW-1:0]   win_idx;
    logic [WIDTH-1:0] win_op;
    logic             shift_out;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] result;

    // Bits pass unchanged up to and including the first 1, inverted after it.
    assign shift_out = seen_q ? ~sr_q[0] : sr_q[0];
    assign sr_shift  = {shift_out, sr_q[WIDTH-1:1]};

`ifdef NEGSCHED_SAT_EN
    assign result = min_op_q ? {1'b0, {(WIDTH-1){1'b1}}} : sr_shift;
`else
    assign result = sr_shift;
`endif

    // Round-robin pick: scan starts one past the last winner.
    always_comb begin
        int idx;
        idx       = 0;
        win_valid = 1'b0;
        win_idx   = '0;
        win_op    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last_q) + k) % NREQ;
            if (!win_valid && req_i[idx]) begin
                win_valid = 1'b1;
                win_idx   = idx[IDW-1:0];
                win_op    = din_i[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        seen_d    = seen_q;
        id_d      = id_q;
        rr_last_d = rr_last_q;
        min_op_d  = min_op_q;
        gnt_d     = '0;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        dout_d    = dout_q;
        ovf_d     = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (win_valid) begin
                    state_d         = S_SHIFT;
                    gnt_d[win_idx]  = 1'b1;
                    sr_d            = win_op;
                    id_d            = win_idx;
                    seen_d          = 1'b0;
                    cnt_d           = '0;
                    rr_last_d       = win_idx;
                    min_op_d        = (win_op == c_MIN_NEG);
                end
            end
            S_SHIFT: begin
                sr_d   = sr_shift;
                seen_d = seen_q | sr_q[0];
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d   = S_DONE;
                    dout_d    = result;
                    done_d    = 1'b1;
                    done_id_d = id_q;
                    ovf_d     = min_op_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sr_q      <= '0;
            seen_q    <= 1'b0;
            id_q      <= '0;
            rr_last_q <= IDW'(NREQ-1);
            min_op_q  <= 1'b0;
            gnt_q     <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sr_q      <= sr_d;
            seen_q    <= seen_d;
            id_q      <= id_d;
            rr_last_q <= rr_last_d;
            min_op_q  <= min_op_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            dout_q    <= dout_d;
            ovf_q     <= ovf_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign dout_o    = dout_q;
    assign ovf_o     = ovf_q;

endmodule
`default_nettype wire
